// File: rtl/imu_sample2bram.sv
// IMU capture stage: a free-running sample timer requests one IMU sample at a time.
// Each sample is written as whole words into a BRAM, and the block flags when a recording is ready to dump.
module imu_sample2bram #(
   parameter int ADDR_WIDTH       = 13,
   parameter int DATA_WIDTH       = 16,
   parameter int WORDS_PER_SAMPLE = 6,
   parameter int CLK_FREQ         = 125000000,
   parameter int SAMPLE_RATE      = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  record,
   output logic                  imu_req,
   input  logic                  imu_valid,
   input  logic [DATA_WIDTH-1:0] imu_data,
   output logic [ADDR_WIDTH-1:0] addr_bram,
   output logic [DATA_WIDTH-1:0] din_bram,
   output logic                  en_bram,
   output logic                  we_bram,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  imu_get_data,
   output logic                  overrun
);
   localparam int N     = CLK_FREQ / SAMPLE_RATE;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int TW    = (N > 1) ? $clog2(N) : 1;
   localparam int SW    = $clog2(WORDS_PER_SAMPLE + 1);
   localparam int CW    = ADDR_WIDTH + 1;
   localparam logic [TW-1:0] TICK_VAL  = TW'(N - 1);
   localparam logic [SW-1:0] LAST_WORD = SW'(WORDS_PER_SAMPLE - 1);
   localparam logic [CW-1:0] STOP_LIM  = CW'(DEPTH - WORDS_PER_SAMPLE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_CAPT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_record_d;
   logic [TW-1:0]         r_timer;
   logic [SW-1:0]         r_sw;
   logic [CW-1:0]         r_word_count;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_din;
   logic                  r_en;
   logic                  r_req;
   logic                  r_get;
   logic                  r_ovr;

   logic                  w_rise;
   logic                  w_start;
   logic                  w_tick;
   logic                  w_run;
   logic                  w_write;
   logic                  w_last_word;
   logic [CW-1:0]         w_cnt_inc;
   logic                  w_stop;

   assign w_rise      = record & ~r_record_d;
   assign w_start     = w_rise & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_tick      = (r_timer == TICK_VAL);
   assign w_run       = (r_state == S_WAIT) | (r_state == S_CAPT);
   assign w_write     = (r_state == S_CAPT) & imu_valid;
   assign w_last_word = (r_sw == LAST_WORD);
   assign w_cnt_inc   = r_word_count + CW'(1);
   // Stop is only consulted on the last word of a sample, so the buffer holds whole samples.
   assign w_stop      = ~record | (w_cnt_inc > STOP_LIM);

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_rise) w_next = S_WAIT;
            else        w_next = S_IDLE;
         end
         S_WAIT: begin
            if (!record) begin
               if (r_word_count == '0) w_next = S_IDLE;
               else                    w_next = S_DONE;
            end else if (w_tick) begin
               w_next = S_CAPT;
            end else begin
               w_next = S_WAIT;
            end
         end
         S_CAPT: begin
            if (w_write && w_last_word) begin
               if (w_stop) w_next = S_DONE;
               else        w_next = S_WAIT;
            end else begin
               w_next = S_CAPT;
            end
         end
         S_DONE: begin
            if (w_rise) w_next = S_WAIT;
            else        w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // Timer, counters, BRAM write port and status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_record_d   <= 1'b0;
         r_timer      <= '0;
         r_sw         <= '0;
         r_word_count <= '0;
         r_addr       <= '0;
         r_din        <= '0;
         r_en         <= 1'b0;
         r_req        <= 1'b0;
         r_get        <= 1'b0;
         r_ovr        <= 1'b0;
      end else begin
         r_record_d <= record;
         r_req      <= (r_state == S_WAIT) & record & w_tick;
         r_en       <= w_write;
         if (w_write) begin
            r_addr <= r_word_count[ADDR_WIDTH-1:0];
            r_din  <= imu_data;
         end
         if (w_start) begin
            r_timer      <= '0;
            r_sw         <= '0;
            r_word_count <= '0;
            r_ovr        <= 1'b0;
            r_get        <= 1'b0;
         end else begin
            if (w_run) r_timer <= w_tick ? '0 : r_timer + TW'(1);
            if ((r_state == S_WAIT) && w_tick) r_sw <= '0;
            else if (w_write)                  r_sw <= r_sw + SW'(1);
            if (w_write) r_word_count <= w_cnt_inc;
            // A tick landing mid-sample is dropped but remembered.
            if ((r_state == S_CAPT) && w_tick) r_ovr <= 1'b1;
            if ((r_state == S_DONE) ||
                ((r_state == S_WAIT) && !record && (r_word_count != '0))) r_get <= 1'b1;
         end
      end
   end

   assign imu_req      = r_req;
   assign addr_bram    = r_addr;
   assign din_bram     = r_din;
   assign en_bram      = r_en;
   assign we_bram      = r_en;
   assign word_count   = r_word_count;
   assign imu_get_data = r_get;
   assign overrun      = r_ovr;
endmodule

// File: tb/tb_imu_sample2bram.sv
// Directed/randomized bench for imu_sample2bram: request timing is predicted from tick arithmetic,
// and BRAM writes are checked against a queue of the words the bench itself supplied.
module tb_imu_sample2bram;
   localparam int AW  = 5;
   localparam int DW  = 16;
   localparam int WPS = 6;
   localparam int N   = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          record;
   logic          imu_valid;
   logic [DW-1:0] imu_data;
   logic          imu_req;
   logic [AW-1:0] addr_bram;
   logic [DW-1:0] din_bram;
   logic          en_bram;
   logic          we_bram;
   logic [AW:0]   word_count;
   logic          imu_get_data;
   logic          overrun;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int we_bad = 0;
   int m_cnt  = 0;
   int rise   = 0;
   int c      = 0;
   int req_q[$];
   logic [AW+DW-1:0] wr_q[$];
   logic [AW+DW-1:0] exp_q[$];

   imu_sample2bram #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_SAMPLE(WPS),
      .CLK_FREQ(1000), .SAMPLE_RATE(100)
   ) dut (
      .clk(clk), .rst(rst), .record(record), .imu_req(imu_req),
      .imu_valid(imu_valid), .imu_data(imu_data), .addr_bram(addr_bram),
      .din_bram(din_bram), .en_bram(en_bram), .we_bram(we_bram),
      .word_count(word_count), .imu_get_data(imu_get_data), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Posedge counter used to timestamp requests.
   always @(posedge clk) cyc <= cyc + 1;

   // Log requests and writes seen on the falling edge.
   always @(negedge clk) begin
      if (imu_req) req_q.push_back(cyc);
      if (en_bram) wr_q.push_back({addr_bram, din_bram});
      if (we_bram !== en_bram) we_bad++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc_n(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_req(input int max, output int rc);
      rc = -1;
      for (int i = 0; i < max; i++) begin
         if (req_q.size() > 0) break;
         cyc_n(1);
      end
      if (req_q.size() > 0) rc = req_q.pop_front();
      else chk("req_timeout", 32'd0, 32'd1);
   endtask

   // Answer one request with WPS words; the last word may be delayed and may drop record.
   task automatic send_sample(input int gap_last, input bit drop, input logic [DW-1:0] base, input bit fixed);
      logic [DW-1:0] d;
      for (int w = 0; w < WPS; w++) begin
         if (w == WPS - 1 && gap_last > 0) begin
            imu_valid = 1'b0;
            cyc_n(gap_last);
         end
         d = fixed ? base + DW'(3 * w) : DW'($urandom);
         imu_valid = 1'b1;
         imu_data  = d;
         if (w == WPS - 1 && drop) record = 1'b0;
         exp_q.push_back({AW'(m_cnt), d});
         m_cnt++;
         cyc_n(1);
      end
      imu_valid = 1'b0;
      imu_data  = DW'($urandom);
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
      while (wr_q.size() > 0 && exp_q.size() > 0)
         chk({tag, "_write"}, 32'(wr_q.pop_front()), 32'(exp_q.pop_front()));
      wr_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b0; record = 1'b0; imu_valid = 1'b0; imu_data = '0;
      cyc_n(3);
      chk("rst_req", 32'(imu_req), 32'd0);
      chk("rst_en", 32'(en_bram), 32'd0);
      chk("rst_we", 32'(we_bram), 32'd0);
      chk("rst_addr", 32'(addr_bram), 32'd0);
      chk("rst_din", 32'(din_bram), 32'd0);
      chk("rst_count", 32'(word_count), 32'd0);
      chk("rst_get", 32'(imu_get_data), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      rst = 1'b1;
      cyc_n(2 * N);
      chk("idle_noreq", 32'(req_q.size()), 32'd0);
      chk("idle_nowrite", 32'(wr_q.size()), 32'd0);

      // Single sample, record dropped with the last word.
      record = 1'b1; rise = cyc + 1; m_cnt = 0;
      wait_req(3 * N, c);
      chk("first_req_lat", 32'(c - rise), 32'(N));
      send_sample(0, 1'b1, 16'h1234, 1'b1);
      chk("single_last_en", 32'(en_bram), 32'd1);
      chk("single_last_addr", 32'(addr_bram), 32'd5);
      chk("single_last_din", 32'(din_bram), 32'h1243);
      chk("single_count", 32'(word_count), 32'd6);
      chk("single_get_early", 32'(imu_get_data), 32'd0);
      cyc_n(1);
      chk("single_get", 32'(imu_get_data), 32'd1);
      chk("single_en_off", 32'(en_bram), 32'd0);
      check_writes("single");
      cyc_n(2 * N);
      chk("single_noreq", 32'(req_q.size()), 32'd0);

      // Buffer full: five whole samples then DONE.
      record = 1'b1; rise = cyc + 1; m_cnt = 0;
      cyc_n(1);
      chk("full_get_drop", 32'(imu_get_data), 32'd0);
      chk("full_count_clr", 32'(word_count), 32'd0);
      for (int s = 0; s < 5; s++) begin
         wait_req(2 * N, c);
         chk("full_req_time", 32'(c - rise), 32'(N * (s + 1)));
         send_sample($urandom_range(0, 2), 1'b0, '0, 1'b0);
      end
      cyc_n(3 * N);
      chk("full_noreq", 32'(req_q.size()), 32'd0);
      chk("full_count", 32'(word_count), 32'd30);
      chk("full_get", 32'(imu_get_data), 32'd1);
      chk("full_ovr", 32'(overrun), 32'd0);
      check_writes("full");

      // Spurious valid in DONE, then restart and an overrun.
      imu_valid = 1'b1; imu_data = DW'($urandom);
      cyc_n(2);
      imu_valid = 1'b0;
      cyc_n(2);
      chk("done_nowrite", 32'(wr_q.size()), 32'd0);
      record = 1'b0;
      cyc_n(2);
      record = 1'b1; rise = cyc + 1; m_cnt = 0;
      cyc_n(1);
      chk("restart_get", 32'(imu_get_data), 32'd0);
      chk("restart_count", 32'(word_count), 32'd0);
      wait_req(2 * N, c);
      chk("ovr_req1", 32'(c - rise), 32'(N));
      send_sample(12, 1'b0, '0, 1'b0);
      chk("ovr_flag", 32'(overrun), 32'd1);
      wait_req(2 * N, c);
      chk("ovr_req2", 32'(c - rise), 32'(3 * N));
      send_sample(0, 1'b1, '0, 1'b0);
      cyc_n(1);
      chk("ovr_get", 32'(imu_get_data), 32'd1);
      chk("ovr_count", 32'(word_count), 32'd12);
      chk("ovr_sticky", 32'(overrun), 32'd1);
      check_writes("ovr");

      // Reset mid-capture after three words.
      cyc_n(2);
      record = 1'b1; rise = cyc + 1; m_cnt = 0;
      wait_req(2 * N, c);
      chk("rstcap_req", 32'(c - rise), 32'(N));
      for (int w = 0; w < 3; w++) begin
         imu_valid = 1'b1;
         imu_data  = DW'($urandom);
         exp_q.push_back({AW'(m_cnt), imu_data});
         m_cnt++;
         cyc_n(1);
      end
      chk("rstcap_en_pre", 32'(en_bram), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("rstcap_en", 32'(en_bram), 32'd0);
      chk("rstcap_we", 32'(we_bram), 32'd0);
      cyc_n(2);
      record = 1'b0; imu_valid = 1'b0; rst = 1'b1;
      cyc_n(2 * N + 2);
      check_writes("rstcap");
      chk("rstcap_noreq", 32'(req_q.size()), 32'd0);
      chk("rstcap_count", 32'(word_count), 32'd0);
      chk("rstcap_get", 32'(imu_get_data), 32'd0);
      chk("we_eq_en", 32'(we_bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
